// File: rtl/decode_stage.sv
// decode_stage: registered, flow-controlled RV32I decode with a one-entry skid buffer and flush.
// Ports: clk/reset (sync, active-high); i_instr/i_pc/i_valid/o_ready from fetch; i_flush drops held micro-ops;
// o_valid/i_ready to rename with the decoded bundle o_pc, o_rs1/o_rs2/o_rd, o_imm, o_funct3, o_funct7b5,
// o_alu_op, o_alu_src, o_pc_src, o_fu_type, o_branch, o_jump, o_mem_read, o_mem_write, o_reg_write, o_illegal.
module decode_stage #(
  parameter int XLEN              = 32,
  parameter bit FLUSH_KEEPS_INPUT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_funct3,
  output logic            o_funct7b5,
  output logic [1:0]      o_alu_op,
  output logic            o_alu_src,
  output logic            o_pc_src,
  output logic [1:0]      o_fu_type,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_reg_write,
  output logic            o_illegal
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            pc_src;
    logic [1:0]      fu_type;
    logic            branch;
    logic            jump;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            illegal;
  } uop_t;
  uop_t        r_out, r_skid, w_dec;
  logic        r_out_v, r_skid_v;
  logic        w_acc, w_drain;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op;
  logic        w_use_rs1, w_use_rs2, w_use_rd;
  logic [31:0] w_imm32;
  assign w_lui   = i_instr[6:0] == 7'b0110111;
  assign w_auipc = i_instr[6:0] == 7'b0010111;
  assign w_jal   = i_instr[6:0] == 7'b1101111;
  assign w_jalr  = i_instr[6:0] == 7'b1100111;
  assign w_br    = i_instr[6:0] == 7'b1100011;
  assign w_ld    = i_instr[6:0] == 7'b0000011;
  assign w_st    = i_instr[6:0] == 7'b0100011;
  assign w_opi   = i_instr[6:0] == 7'b0010011;
  assign w_op    = i_instr[6:0] == 7'b0110011;
  assign w_use_rs1 = w_jalr | w_br | w_ld | w_st | w_opi | w_op;
  assign w_use_rs2 = w_br | w_st | w_op;
  assign w_use_rd  = w_lui | w_auipc | w_jal | w_jalr | w_ld | w_opi | w_op;
  assign w_imm32 = (w_jalr | w_ld | w_opi) ? {{20{i_instr[31]}}, i_instr[31:20]} :
                   w_st  ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
                   w_br  ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                   (w_lui | w_auipc) ? {i_instr[31:12], 12'b0} :
                   w_jal ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                   32'd0;
  always_comb begin
    w_dec           = '0;
    w_dec.pc        = i_pc;
    w_dec.rs1       = w_use_rs1 ? i_instr[19:15] : 5'd0;
    w_dec.rs2       = w_use_rs2 ? i_instr[24:20] : 5'd0;
    w_dec.rd        = w_use_rd ? i_instr[11:7] : 5'd0;
    w_dec.imm       = XLEN'($signed(w_imm32));
    w_dec.funct3    = i_instr[14:12];
    w_dec.funct7b5  = (w_op | (w_opi & i_instr[14:12] == 3'b101)) & i_instr[30];
    w_dec.alu_op    = w_br ? 2'b01 : w_op ? 2'b10 : w_opi ? 2'b11 : 2'b00;
    w_dec.alu_src   = w_lui | w_auipc | w_jal | w_jalr | w_ld | w_st | w_opi;
    w_dec.pc_src    = w_auipc | w_jal;
    w_dec.fu_type   = (w_br | w_jal | w_jalr) ? 2'b01 : (w_ld | w_st) ? 2'b10 : 2'b00;
    w_dec.branch    = w_br;
    w_dec.jump      = w_jal | w_jalr;
    w_dec.mem_read  = w_ld;
    w_dec.mem_write = w_st;
    w_dec.reg_write = w_use_rd & (i_instr[11:7] != 5'd0);
    w_dec.illegal   = !(w_use_rd | w_br | w_st);
  end
  // Ready depends only on registered state so no combinational path from i_ready.
  assign o_ready = !r_skid_v & !reset;
  assign w_acc   = i_valid & o_ready;
  assign w_drain = r_out_v & i_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out    <= '0;
      r_skid   <= '0;
    end else if (i_flush) begin
      r_out_v  <= FLUSH_KEEPS_INPUT & w_acc;
      r_skid_v <= 1'b0;
      if (FLUSH_KEEPS_INPUT && w_acc) r_out <= w_dec;
    end else if (!r_out_v || w_drain) begin
      // Skid is only full when o_ready was low, so it never competes with a new input here.
      r_out_v  <= r_skid_v | w_acc;
      r_skid_v <= 1'b0;
      if (r_skid_v) r_out <= r_skid;
      else if (w_acc) r_out <= w_dec;
    end else if (w_acc) begin
      r_skid_v <= 1'b1;
      r_skid   <= w_dec;
    end
  end
  assign o_valid     = r_out_v;
  assign o_pc        = r_out.pc;
  assign o_rs1       = r_out.rs1;
  assign o_rs2       = r_out.rs2;
  assign o_rd        = r_out.rd;
  assign o_imm       = r_out.imm;
  assign o_funct3    = r_out.funct3;
  assign o_funct7b5  = r_out.funct7b5;
  assign o_alu_op    = r_out.alu_op;
  assign o_alu_src   = r_out.alu_src;
  assign o_pc_src    = r_out.pc_src;
  assign o_fu_type   = r_out.fu_type;
  assign o_branch    = r_out.branch;
  assign o_jump      = r_out.jump;
  assign o_mem_read  = r_out.mem_read;
  assign o_mem_write = r_out.mem_write;
  assign o_reg_write = r_out.reg_write;
  assign o_illegal   = r_out.illegal;
endmodule
